// File: rtl/inst_encoder_if.sv
// -----------------------------------------------------------------------------
// inst_encoder_if
// Purpose : Bundles the field-level instruction input handshake and the
//           instruction-memory write port of inst_encoder.
// Signals : in_valid/in_ready  field bundle handshake
//           fmt, funct3, funct7, rd, rs1, rs2, imm, last  decoded fields
//           mem_we/mem_ack      memory write request / accept
//           mem_addr, mem_wdata word address and encoded instruction
// Modports: master - bundle producer and memory responder (boot loader, bench)
//           slave  - the encoder itself
// -----------------------------------------------------------------------------
interface inst_encoder_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [4:0]        rd;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [31:0]       imm;
    logic              last;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;

    modport master (
        output in_valid, fmt, funct3, funct7, rd, rs1, rs2, imm, last, mem_ack,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, fmt, funct3, funct7, rd, rs1, rs2, imm, last, mem_ack,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/inst_encoder.sv
// -----------------------------------------------------------------------------
// inst_encoder
// Purpose : Assembles RV32I instruction words from decoded fields and writes
//           them sequentially into instruction memory over a req/ack port.
// Ports   : clk    rising-edge clock
//           rst_n  asynchronous active-low reset
//           start  begin a new program (only honoured while idle)
//           bus    inst_encoder_if.slave: field handshake + memory write port
//           busy   high in every state except idle
//           done   one-cycle pulse after the final write
//           count  words written since the last start (wraps)
//           err    sticky encode error
// Options : INST_ENC_CHECK_EN - check each bundle at handshake; a bad bundle
//           sets err and is consumed without a write. Undefined: err is 0
//           and fields are truncated silently.
// -----------------------------------------------------------------------------
module inst_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    inst_encoder_if.slave     bus,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   count,
    output logic              err
);
    typedef enum logic [1:0] {S_IDLE, S_ACCEPT, S_WRITE, S_DONE} state_t;

    state_t            r_state;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [31:0]       r_mem_wdata;
    logic              r_last;
    logic              r_busy;
    logic              r_done;
    logic [ADDR_W:0]   r_count;
    logic              r_err;

    logic [31:0]       w_word;
    logic              w_chk_err;

    // Field assembly, standard RV32I bit placement.
    always_comb begin
        w_word = '0;
        case (bus.fmt)
            3'd0: w_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, 7'b0110011};
            3'd1: w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0000011};
            3'd2: begin
                // Shift-immediates carry funct7 in the upper immediate bits.
                if (bus.funct3 == 3'b001 || bus.funct3 == 3'b101)
                    w_word = {bus.funct7, bus.imm[4:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
                else
                    w_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, 7'b0010011};
            end
            3'd3: w_word = {bus.imm[11:0], bus.rs1, 3'b000, bus.rd, 7'b1100111};
            3'd4: w_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3, bus.imm[4:0], 7'b0100011};
            3'd5: w_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                            bus.imm[4:1], bus.imm[11], 7'b1100011};
            3'd6: w_word = {bus.imm[31:12], bus.rd, 7'b0110111};
            3'd7: w_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                            bus.rd, 7'b1101111};
            default: w_word = '0;
        endcase
    end

`ifdef INST_ENC_CHECK_EN
    // An N-bit signed value fits when all bits from N-1 upward agree.
    logic w_fit12, w_fit13, w_fit21, w_f3_slt;
    assign w_fit12  = (&bus.imm[31:11]) | ~(|bus.imm[31:11]);
    assign w_fit13  = (&bus.imm[31:12]) | ~(|bus.imm[31:12]);
    assign w_fit21  = (&bus.imm[31:20]) | ~(|bus.imm[31:20]);
    assign w_f3_slt = (bus.funct3 == 3'b010) || (bus.funct3 == 3'b011);

    always_comb begin
        w_chk_err = 1'b0;
        case (bus.fmt)
            3'd0: w_chk_err = !(bus.funct7 == 7'h00 || bus.funct7 == 7'h20) || w_f3_slt;
            3'd1, 3'd3, 3'd4: w_chk_err = !w_fit12;
            3'd2: w_chk_err = w_f3_slt || !w_fit12;
            3'd5: w_chk_err = !(bus.funct3 == 3'b000 || bus.funct3 == 3'b001 ||
                                bus.funct3 == 3'b100 || bus.funct3 == 3'b101) ||
                              !w_fit13 || bus.imm[0];
            3'd7: w_chk_err = !w_fit21 || bus.imm[0];
            default: w_chk_err = 1'b0;
        endcase
    end
`else
    assign w_chk_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= ADDR_W'(BASE_ADDR);
            r_mem_wdata <= '0;
            r_last      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_count     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state    <= S_ACCEPT;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b1;
                        r_mem_addr <= ADDR_W'(BASE_ADDR);
                        r_count    <= '0;
                        r_err      <= 1'b0;
                    end
                end
                S_ACCEPT: begin
                    if (bus.in_valid) begin
                        if (w_chk_err) begin
                            // Rejected bundle is consumed; only its last flag matters.
                            r_err <= 1'b1;
                            if (bus.last) begin
                                r_state    <= S_DONE;
                                r_in_ready <= 1'b0;
                                r_done     <= 1'b1;
                            end
                        end else begin
                            r_state     <= S_WRITE;
                            r_in_ready  <= 1'b0;
                            r_mem_we    <= 1'b1;
                            r_mem_wdata <= w_word;
                            r_last      <= bus.last;
                        end
                    end
                end
                S_WRITE: begin
                    if (bus.mem_ack) begin
                        r_mem_we   <= 1'b0;
                        r_mem_addr <= r_mem_addr + ADDR_W'(1);
                        r_count    <= r_count + (ADDR_W+1)'(1);
                        if (r_last) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state    <= S_ACCEPT;
                            r_in_ready <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_in_ready <= 1'b0;
                    r_mem_we   <= 1'b0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.mem_we    = r_mem_we;
    assign bus.mem_addr  = r_mem_addr;
    assign bus.mem_wdata = r_mem_wdata;
    assign busy          = r_busy;
    assign done          = r_done;
    assign count         = r_count;
    assign err           = r_err;
endmodule

// File: tb/tb_inst_encoder.sv
module tb_inst_encoder;
    localparam int AW = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, err;
    logic [AW:0]   count;

    inst_encoder_if #(.ADDR_W(AW)) bus ();

    inst_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .bus   (bus),
        .busy  (busy),
        .done  (done),
        .count (count),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    logic [AW-1:0] exp_addr;
    logic [AW:0]   exp_count;
    int          total = 0;
    int          bad   = 0;
    bit          ok;

    // Pulse start for one cycle; returns at a negedge with the DUT in ACCEPT.
    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        exp_addr  = '0;
        exp_count = '0;
    endtask

    // Present a bundle at a negedge and hold it until accepted; returns at the
    // negedge following the handshake edge.
    task automatic send(input logic [2:0] f, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [4:0] d, input logic [4:0] s1, input logic [4:0] s2,
                        input logic [31:0] im, input logic lst, output bit hs);
        bus.in_valid = 1'b1;
        bus.fmt = f; bus.funct3 = f3; bus.funct7 = f7;
        bus.rd = d; bus.rs1 = s1; bus.rs2 = s2; bus.imm = im; bus.last = lst;
        hs = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.in_ready === 1'b1) begin
                hs = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (hs) @(negedge clk);
        bus.in_valid = 1'b0;
        bus.last     = 1'b0;
        if (!hs) begin
            total++; bad++;
            $display("FAIL handshake: in_ready=%b after 40 cycles, want 1", bus.in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; bus.in_valid = 1'b0; bus.mem_ack = 1'b0;
        bus.fmt = '0; bus.funct3 = '0; bus.funct7 = '0; bus.rd = '0;
        bus.rs1 = '0; bus.rs2 = '0; bus.imm = '0; bus.last = 1'b0;
        #12;
        total++;
        if ({busy, done, err, bus.in_ready, bus.mem_we} !== 5'b0) begin
            bad++;
            $display("FAIL reset_ctrl: busy/done/err/rdy/we=%b want 00000",
                     {busy, done, err, bus.in_ready, bus.mem_we});
        end
        total++;
        if (bus.mem_addr !== '0 || bus.mem_wdata !== '0 || count !== '0) begin
            bad++;
            $display("FAIL reset_data: addr=%0d data=%h count=%0d want 0 0 0",
                     bus.mem_addr, bus.mem_wdata, count);
        end
        @(negedge clk) rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL idle_hold: busy=%b rdy=%b want 0 0", busy, bus.in_ready);
        end
    endtask

    task automatic test_addi();
        do_start();
        sb.push_back('{exp_addr, 32'h00500093});
        send(3'd2, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, ok);
        e = sb.pop_front();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
            bad++;
            $display("FAIL addi_write: we=%b addr=%0d data=%h want 1 %0d %h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk) bus.mem_ack = 1'b0;
        exp_count++;
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || count !== exp_count || bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL addi_done: done=%b busy=%b count=%0d we=%b want 1 1 %0d 0",
                     done, busy, count, bus.mem_we, exp_count);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL addi_idle: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_back_to_back();
        do_start();
        bus.mem_ack = 1'b1;
        sb.push_back('{exp_addr, 32'h002081B3});
        send(3'd0, 3'b000, 7'h00, 5'd3, 5'd1, 5'd2, 32'h0, 1'b0, ok);
        e = sb.pop_front();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
            bad++;
            $display("FAIL add_write: we=%b addr=%0d data=%h want 1 %0d %h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
        exp_addr++; exp_count++;
        sb.push_back('{exp_addr, 32'h402081B3});
        send(3'd0, 3'b000, 7'h20, 5'd3, 5'd1, 5'd2, 32'h0, 1'b1, ok);
        e = sb.pop_front();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
            bad++;
            $display("FAIL sub_write: we=%b addr=%0d data=%h want 1 %0d %h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
        exp_addr++; exp_count++;
        @(negedge clk) bus.mem_ack = 1'b0;
        total++;
        if (done !== 1'b1 || busy !== 1'b1 || count !== exp_count) begin
            bad++;
            $display("FAIL b2b_done: done=%b busy=%b count=%0d want 1 1 %0d",
                     done, busy, count, exp_count);
        end
        @(negedge clk);
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL b2b_idle: done=%b busy=%b want 0 0", done, busy);
        end
    endtask

    task automatic test_slow_ack();
        logic [31:0] words [2];
        words[0] = 32'h0020A423;
        words[1] = 32'hFE208EE3;
        do_start();
        for (int n = 0; n < 2; n++) begin
            sb.push_back('{exp_addr, words[n]});
            if (n == 0) send(3'd4, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, ok);
            else        send(3'd5, 3'b000, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, 1'b1, ok);
            e = sb.pop_front();
            for (int c = 0; c < 6; c++) begin
                total++;
                if (bus.mem_we !== 1'b1 || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                    bad++;
                    $display("FAIL slow_hold[%0d] cyc%0d: we=%b addr=%0d data=%h want 1 %0d %h",
                             n, c, bus.mem_we, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
                end
                if (c < 5) @(negedge clk);
            end
            bus.mem_ack = 1'b1;
            @(negedge clk) bus.mem_ack = 1'b0;
            exp_addr++; exp_count++;
            if (n == 0) begin
                total++;
                if (bus.in_ready !== 1'b1 || bus.mem_we !== 1'b0 || count !== exp_count) begin
                    bad++;
                    $display("FAIL slow_accept: rdy=%b we=%b count=%0d want 1 0 %0d",
                             bus.in_ready, bus.mem_we, count, exp_count);
                end
            end
        end
        total++;
        if (done !== 1'b1 || count !== exp_count) begin
            bad++;
            $display("FAIL slow_done: done=%b count=%0d want 1 %0d", done, count, exp_count);
        end
        @(negedge clk);
    endtask

    // Unused fields carry junk that must not reach the encoded word.
    task automatic test_jal_lui();
        do_start();
        sb.push_back('{exp_addr, 32'h008000EF});
        send(3'd7, 3'b101, 7'h7F, 5'd1, 5'd31, 5'd17, 32'd8, 1'b0, ok);
        e = sb.pop_front();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
            bad++;
            $display("FAIL jal_write: we=%b addr=%0d data=%h want 1 %0d %h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk) bus.mem_ack = 1'b0;
        exp_addr++; exp_count++;
        sb.push_back('{exp_addr, 32'h123452B7});
        send(3'd6, 3'b011, 7'h55, 5'd5, 5'd9, 5'd30, 32'h12345000, 1'b1, ok);
        e = sb.pop_front();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
            bad++;
            $display("FAIL lui_write: we=%b addr=%0d data=%h want 1 %0d %h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk) bus.mem_ack = 1'b0;
        @(negedge clk);
    endtask

    // Five writes across a 4-word memory; a start pulse mid-program is ignored.
    task automatic test_wrap();
        logic [2:0]  fa  [5];
        logic [2:0]  f3a [5];
        logic [6:0]  f7a [5];
        logic [4:0]  rda [5];
        logic [4:0]  s1a [5];
        logic [31:0] ima [5];
        logic [31:0] wa  [5];
        fa[0] = 3'd2; f3a[0] = 3'b001; f7a[0] = 7'h00; rda[0] = 5'd2; s1a[0] = 5'd1; ima[0] = 32'd3;          wa[0] = 32'h00309113;
        fa[1] = 3'd2; f3a[1] = 3'b101; f7a[1] = 7'h20; rda[1] = 5'd2; s1a[1] = 5'd1; ima[1] = 32'd3;          wa[1] = 32'h4030D113;
        fa[2] = 3'd3; f3a[2] = 3'b111; f7a[2] = 7'h00; rda[2] = 5'd1; s1a[2] = 5'd2; ima[2] = 32'd4;          wa[2] = 32'h004100E7;
        fa[3] = 3'd1; f3a[3] = 3'b010; f7a[3] = 7'h00; rda[3] = 5'd5; s1a[3] = 5'd1; ima[3] = 32'hFFFFFFF8;   wa[3] = 32'hFF80A283;
        fa[4] = 3'd2; f3a[4] = 3'b000; f7a[4] = 7'h00; rda[4] = 5'd1; s1a[4] = 5'd0; ima[4] = 32'd5;          wa[4] = 32'h00500093;
        do_start();
        for (int i = 0; i < 5; i++) begin
            sb.push_back('{exp_addr, wa[i]});
            send(fa[i], f3a[i], f7a[i], rda[i], s1a[i], 5'd0, ima[i], (i == 4), ok);
            e = sb.pop_front();
            total++;
            if (bus.mem_we !== 1'b1 || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
                bad++;
                $display("FAIL wrap_write[%0d]: we=%b addr=%0d data=%h want 1 %0d %h",
                         i, bus.mem_we, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
            end
            bus.mem_ack = 1'b1;
            @(negedge clk) bus.mem_ack = 1'b0;
            exp_addr++; exp_count++;
            if (i == 1) begin
                start = 1'b1;
                @(negedge clk) start = 1'b0;
            end
        end
        total++;
        if (done !== 1'b1 || count !== exp_count || bus.mem_addr !== exp_addr) begin
            bad++;
            $display("FAIL wrap_done: done=%b count=%0d addr=%0d want 1 %0d %0d",
                     done, count, bus.mem_addr, exp_count, exp_addr);
        end
        @(negedge clk);
    endtask

    task automatic test_check();
`ifdef INST_ENC_CHECK_EN
        do_start();
        send(3'd2, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b0, ok);
        total++;
        if (err !== 1'b1 || bus.mem_we !== 1'b0 || bus.in_ready !== 1'b1 || count !== exp_count) begin
            bad++;
            $display("FAIL chk_reject: err=%b we=%b rdy=%b count=%0d want 1 0 1 %0d",
                     err, bus.mem_we, bus.in_ready, count, exp_count);
        end
        sb.push_back('{exp_addr, 32'h00500093});
        send(3'd2, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b0, ok);
        e = sb.pop_front();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
            bad++;
            $display("FAIL chk_next_write: we=%b addr=%0d data=%h want 1 %0d %h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk) bus.mem_ack = 1'b0;
        exp_addr++; exp_count++;
        send(3'd7, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3, 1'b1, ok);
        total++;
        if (done !== 1'b1 || err !== 1'b1 || count !== exp_count || bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL chk_last: done=%b err=%b count=%0d we=%b want 1 1 %0d 0",
                     done, err, count, bus.mem_we, exp_count);
        end
`else
        do_start();
        sb.push_back('{exp_addr, 32'h00000093});
        send(3'd2, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd4096, 1'b1, ok);
        e = sb.pop_front();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
            bad++;
            $display("FAIL trunc_write: we=%b addr=%0d data=%h want 1 %0d %h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk) bus.mem_ack = 1'b0;
        exp_count++;
        total++;
        if (done !== 1'b1 || err !== 1'b0 || count !== exp_count) begin
            bad++;
            $display("FAIL trunc_done: done=%b err=%b count=%0d want 1 0 %0d",
                     done, err, count, exp_count);
        end
`endif
        @(negedge clk);
    endtask

    task automatic test_reset_mid_write();
        do_start();
        sb.push_back('{exp_addr, 32'h0020A423});
        send(3'd4, 3'b010, 7'h00, 5'd0, 5'd1, 5'd2, 32'd8, 1'b0, ok);
        e = sb.pop_front();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_wdata !== e.data) begin
            bad++;
            $display("FAIL rst_pre: we=%b data=%h want 1 %h", bus.mem_we, bus.mem_wdata, e.data);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (bus.mem_we !== 1'b0) begin
            bad++;
            $display("FAIL rst_async_we: we=%b want 0", bus.mem_we);
        end
        total++;
        if ({busy, done, err, bus.in_ready} !== 4'b0 || bus.mem_addr !== '0 ||
            bus.mem_wdata !== '0 || count !== '0) begin
            bad++;
            $display("FAIL rst_outputs: bdei=%b addr=%0d data=%h count=%0d want 0000 0 0 0",
                     {busy, done, err, bus.in_ready}, bus.mem_addr, bus.mem_wdata, count);
        end
        @(negedge clk) rst_n = 1'b1;
        do_start();
        sb.push_back('{exp_addr, 32'h008000EF});
        send(3'd7, 3'b000, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, ok);
        e = sb.pop_front();
        total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== e.addr || bus.mem_wdata !== e.data) begin
            bad++;
            $display("FAIL rst_restart: we=%b addr=%0d data=%h want 1 %0d %h",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, e.addr, e.data);
        end
        bus.mem_ack = 1'b1;
        @(negedge clk) bus.mem_ack = 1'b0;
        exp_count++;
        total++;
        if (done !== 1'b1 || count !== exp_count) begin
            bad++;
            $display("FAIL rst_count: done=%b count=%0d want 1 %0d", done, count, exp_count);
        end
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_addi();
        test_back_to_back();
        test_slow_ack();
        test_jal_lui();
        test_wrap();
        test_check();
        test_reset_mid_write();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, want finished");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/inst_encoder.md
# inst_encoder

Assembles RISC-V RV32I instruction words from decoded control fields and writes them sequentially into instruction memory over a req/ack write port. It is the inverse of the core's control/ALU-control decode path. Test benches and the boot loader use it to build programs from field-level descriptions. It is the single writer of the instruction memory during program load.

## Interface
Parameters:
- ADDR_W, 10: instruction memory word-address width.
- BASE_ADDR, 0: first word address written after each start.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin new program; ignored unless idle.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder accepts a bundle this cycle.
- fmt  in  3  instruction format:
  - 0 R (0110011), 1 LOAD (0000011), 2 OPIMM (0010011), 3 JALR (1100111)
  - 4 STORE (0100011), 5 BRANCH (1100011), 6 LUI (0110111), 7 JAL (1101111)
- funct3  in  3  funct3 field.
- funct7  in  7  funct7 field; used by R and by OPIMM shifts.
- rd, rs1, rs2  in  5 each  register indices.
- imm  in  32  immediate as a byte offset or value, sign-extended.
- last  in  1  qualifies the bundle as the final instruction.
- mem_we  out  1  write request.
- mem_addr  out  ADDR_W  word address.
- mem_wdata  out  32  encoded instruction.
- mem_ack  in  1  write accepted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final write.
- count  out  ADDR_W+1  words written since the last start.
- err  out  1  sticky encode error (see Configuration).

## Operation
- FSM states: IDLE, ACCEPT, WRITE, DONE.
  - IDLE, start=1 → ACCEPT; mem_addr←BASE_ADDR, count←0, err←0.
  - ACCEPT: in_ready=1. When in_valid, capture the encoded word into mem_wdata and capture last → WRITE.
  - WRITE: mem_we=1; mem_addr and mem_wdata held stable until mem_ack.
    - On mem_ack, mem_addr increments and count increments.
    - If the captured last=1 → DONE, otherwise → ACCEPT.
  - DONE: done=1 for one cycle → IDLE.
- start is ignored outside IDLE.
- mem_addr wraps from 2^ADDR_W−1 to 0. count wraps modulo 2^(ADDR_W+1).
- Encoding uses standard RV32I bit placement:
  - R: funct7|rs2|rs1|funct3|rd|op.
  - I-type (LOAD, OPIMM, JALR): imm[11:0]|rs1|funct3|rd|op. JALR forces funct3=000.
  - OPIMM with funct3=001 or 101: bits[31:25]=funct7, bits[24:20]=imm[4:0].
  - STORE: imm[11:5]|rs2|rs1|funct3|imm[4:0]|op.
  - BRANCH: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|op.
  - LUI: imm[31:12]|rd|op.
  - JAL: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|op.
- Unused input fields for a given format are ignored.
- Reset, including mid-write: state=IDLE, mem_we=0, in_ready=0, busy=0, done=0, mem_addr=BASE_ADDR, mem_wdata=0, count=0, err=0. mem_we drops asynchronously. A write cut off by reset is not counted.

## Timing
- Handshake in cycle N → mem_we, mem_addr and mem_wdata valid from cycle N+1. Encode latency is 1 cycle.
- mem_ack is sampled only while mem_we=1. Ack in cycle N+1 → ACCEPT (in_ready=1) in cycle N+2. Peak throughput is one instruction per 2 cycles.
- Final ack in cycle M → done=1 and busy=1 in cycle M+1 → busy=0 in M+2.
- in_valid with last=1 and mem_addr wrap may coincide; there is no special handling.

## Configuration
- INST_ENC_CHECK_EN defined: each bundle is checked at handshake. An error is any of:
  - R with funct7 ∉ {0x00, 0x20}.
  - R/OPIMM with funct3 ∈ {010, 011}.
  - BRANCH with funct3 ∉ {000, 001, 100, 101}.
  - I/S imm not representable in 12-bit signed.
  - BRANCH imm outside 13-bit signed, or imm[0]=1.
  - JAL imm outside 21-bit signed, or imm[0]=1.
- On error: err←1 (sticky until the next start). The bundle is consumed but not written. FSM stays in ACCEPT. If last=1 → DONE.
- INST_ENC_CHECK_EN undefined: err tied to 0. Fields are truncated silently per the encoding rules.

## Test plan
- start; addi x1,x0,5 (fmt2,f3 000,rd1,imm5) → mem_wdata=0x00500093 at addr 0, count=1.
- Stream add x3,x1,x2 then sub x3,x1,x2 (funct7 0x20,last) with mem_ack held high → 0x002081B3 @0, 0x402081B3 @1, done pulse, count=2.
- sw x2,8(x1) → 0x0020A423; beq x1,x2,-4 → 0xFE208EE3; delay mem_ack 5 cycles → mem_we and data stable throughout.
- jal x1,8 → 0x008000EF; lui x5,0x12345000 → 0x123452B7. ADDR_W=2 with 5 writes → addresses 0,1,2,3,0.
- Assert rst_n low while in WRITE → mem_we=0 immediately; all outputs at reset values; a new start writes from BASE_ADDR.
- With INST_ENC_CHECK_EN: addi imm=4096 → err=1, no write, count unchanged. A following valid bundle is still written.
